// File: rtl/rd_link_pkg.sv
// rd_link_pkg: shared definitions for the RD serial link transmitter.
//   WORD_BITS         - bits per word per lane
//   BITS_PER_WORD_CLK - CLK cycles spent serialising one word (2 CLK per bit)
//   state_e           - transmitter FSM states
package rd_link_pkg;

  localparam int unsigned WORD_BITS         = 12;
  localparam int unsigned BITS_PER_WORD_CLK = 2 * WORD_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/rd_word_serializer.sv
// rd_word_serializer: two-lane parallel-load shift register with the serial
// clock phase bit and the per-word bit counter.
//   clk_i, rst_i   - system clock, synchronous active-high reset
//   load_i         - load data_i (lane 0 = low half, lane 1 = high half)
//   advance_i      - toggle phase; shift one bit on each 1->0 phase edge
//   clear_i        - force every register to 0 (highest priority)
//   lane0_o/1_o    - MSB of each lane shift register
//   sclk_o         - phase bit, used directly as the serial clock
//   last_bit_o     - bit 0 is on the lanes and this is its second CLK
module rd_word_serializer #(
  parameter int unsigned WORD_BITS = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic                   advance_i,
  input  logic                   clear_i,
  input  logic [2*WORD_BITS-1:0] data_i,
  output logic                   lane0_o,
  output logic                   lane1_o,
  output logic                   sclk_o,
  output logic                   last_bit_o
);
  import rd_link_pkg::*;

  localparam int unsigned      CNT_W   = $clog2(WORD_BITS);
  localparam logic [CNT_W-1:0] MSB_IDX = CNT_W'(WORD_BITS - 1);

  logic [WORD_BITS-1:0] sr0_q, sr0_d;
  logic [WORD_BITS-1:0] sr1_q, sr1_d;
  logic                 phase_q, phase_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  always_comb begin
    sr0_d   = sr0_q;
    sr1_d   = sr1_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      sr0_d   = '0;
      sr1_d   = '0;
      phase_d = 1'b0;
      cnt_d   = '0;
    end else if (load_i) begin
      sr0_d   = data_i[WORD_BITS-1:0];
      sr1_d   = data_i[2*WORD_BITS-1:WORD_BITS];
      phase_d = 1'b0;
      cnt_d   = MSB_IDX;
    end else if (advance_i) begin
      phase_d = ~phase_q;
      // Lanes move only on the falling serial clock so data is stable around the rise.
      if (phase_q) begin
        sr0_d = {sr0_q[WORD_BITS-2:0], 1'b0};
        sr1_d = {sr1_q[WORD_BITS-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr0_q   <= '0;
      sr1_q   <= '0;
      phase_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sr0_q   <= sr0_d;
      sr1_q   <= sr1_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lane0_o    = sr0_q[WORD_BITS-1];
  assign lane1_o    = sr1_q[WORD_BITS-1];
  assign sclk_o     = phase_q;
  assign last_bit_o = phase_q && (cnt_q == '0);

endmodule

// File: rtl/rd_serial_tx.sv
// rd_serial_tx: transmit end of the RD serial link. A TRIG_IN rising edge
// reads NUM_WORDS 24-bit words from buffer BUF_NUM and sends both 12-bit
// halves MSB-first on two lanes, framed by ENABLE_XFR_OUT, with SERIAL_CLK_OUT
// running at CLK/2.
//   CLK, RST            - system clock, synchronous active-high reset
//   TRIG_IN, BUF_NUM    - transfer request (rising edge) and buffer select
//   ABORT               - level; ends a running transfer without DONE
//   MEM_ADDR, MEM_DATA  - {buf, word} read address; data one CLK later
//   SERIAL_DATA0/1_OUT, SERIAL_CLK_OUT, ENABLE_XFR_OUT - link outputs
//   BUSY, DONE, TRIG_OVERRUN - status
module rd_serial_tx #(
  parameter int unsigned WORD_BITS = 12,
  parameter int unsigned NUM_WORDS = 2048,
  parameter int unsigned ADDR_W    = 11
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   TRIG_IN,
  input  logic [1:0]             BUF_NUM,
  input  logic                   ABORT,
  output logic [ADDR_W+1:0]      MEM_ADDR,
  input  logic [2*WORD_BITS-1:0] MEM_DATA,
  output logic                   SERIAL_DATA0_OUT,
  output logic                   SERIAL_DATA1_OUT,
  output logic                   SERIAL_CLK_OUT,
  output logic                   ENABLE_XFR_OUT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   TRIG_OVERRUN
);
  import rd_link_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W:0]   NUM_WORDS_W = (ADDR_W+1)'(NUM_WORDS);

  state_e            state_q;
  logic              trig_q;
  logic [1:0]        buf_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] word_q;
  logic              en_q;
  logic              done_q;
  logic              ovr_q;

  logic              trig_rise;
  logic              last_word;
  logic              last_bit;
  logic [ADDR_W:0]   addr_d;
  logic              ser_load, ser_adv, ser_clear;

  assign trig_rise = TRIG_IN && !trig_q;
  assign last_word = (word_q == LAST_IDX);
  // Prefetch runs one word ahead; the wide sum keeps the end-of-buffer compare exact.
  assign addr_d    = {1'b0, word_q} + (ADDR_W+1)'(2);

  always_comb begin
    ser_load  = 1'b0;
    ser_adv   = 1'b0;
    ser_clear = 1'b0;
    case (state_q)
      FETCH: begin
        if (ABORT) ser_clear = 1'b1;
        else       ser_load  = 1'b1;
      end
      SHIFT: begin
        if (ABORT || (last_bit && last_word)) ser_clear = 1'b1;
        else if (last_bit)                    ser_load  = 1'b1;
        else                                  ser_adv   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      trig_q  <= 1'b0;
      buf_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      trig_q <= TRIG_IN;
      done_q <= 1'b0;
      if (state_q != IDLE && trig_rise) ovr_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (trig_rise) begin
            state_q <= FETCH;
            buf_q   <= BUF_NUM;
            addr_q  <= '0;
            word_q  <= '0;
          end
        end
        FETCH: begin
          if (ABORT) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
          end else begin
            state_q <= SHIFT;
            en_q    <= 1'b1;
            addr_q  <= ADDR_W'(1);
          end
        end
        SHIFT: begin
          if (ABORT) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
          end else if (last_bit) begin
            if (last_word) begin
              state_q <= IDLE;
              en_q    <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              word_q <= word_q + ADDR_W'(1);
              if (addr_d < NUM_WORDS_W) addr_q <= addr_d[ADDR_W-1:0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  rd_word_serializer #(
    .WORD_BITS (WORD_BITS)
  ) u_ser (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (ser_load),
    .advance_i  (ser_adv),
    .clear_i    (ser_clear),
    .data_i     (MEM_DATA),
    .lane0_o    (SERIAL_DATA0_OUT),
    .lane1_o    (SERIAL_DATA1_OUT),
    .sclk_o     (SERIAL_CLK_OUT),
    .last_bit_o (last_bit)
  );

  assign MEM_ADDR       = {buf_q, addr_q};
  assign ENABLE_XFR_OUT = en_q;
  assign BUSY           = (state_q != IDLE);
  assign DONE           = done_q;
  assign TRIG_OVERRUN   = ovr_q;

endmodule

// File: doc/rd_serial_tx.md
# rd_serial_tx

Transmit end of the RD serial link. On a trigger it reads one buffer of 24-bit sample pairs from block RAM. It serialises the two 12-bit halves MSB-first on two data lanes, framed by ENABLE_XFR and clocked by a generated serial clock at CLK/2. It drives exactly the link that rd_interface receives (SERIAL_DATA0/1, SERIAL_CLK, ENABLE_XFR) and sits in the RD-side emulator and loopback test path.

## Interface
- WORD_BITS, 12, bits per word per lane
- NUM_WORDS, 2048, words per lane per transfer (≥2)
- ADDR_W, 11, word-index width; must satisfy 2**ADDR_W ≥ NUM_WORDS
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- TRIG_IN  in  1  transfer request; rising edge sampled in CLK domain
- BUF_NUM  in  2  buffer select; latched on the accepted trigger
- ABORT  in  1  level; terminates a transfer immediately
- MEM_ADDR  out  2+ADDR_W  read address {buf, word index}
- MEM_DATA  in  2*WORD_BITS  read data, valid 1 CLK after MEM_ADDR; [11:0] → lane 0, [23:12] → lane 1
- SERIAL_DATA0_OUT, SERIAL_DATA1_OUT  out  1  lane data
- SERIAL_CLK_OUT  out  1  serial clock (CLK/2 during a transfer, else 0)
- ENABLE_XFR_OUT  out  1  high for the whole transfer
- BUSY  out  1  state ≠ IDLE
- DONE  out  1  one-CLK pulse on normal completion
- TRIG_OVERRUN  out  1  sticky; a trigger rose while BUSY; cleared only by RST

## Operation
- States: IDLE → FETCH → SHIFT → IDLE.
- IDLE: all serial outputs 0, BUSY 0.
  - A TRIG_IN rising edge (TRIG_IN=1 with the registered previous value 0) moves to FETCH.
  - On that edge: buf ← BUF_NUM, MEM_ADDR ← {BUF_NUM, 0}.
- FETCH lasts one CLK. On its exit edge:
  - shift registers load MEM_DATA;
  - ENABLE_XFR_OUT ← 1, SERIAL_CLK_OUT stays 0;
  - lanes drive bit 11 of word 0;
  - MEM_ADDR advances to word 1.
- SHIFT: a phase bit toggles every CLK and SERIAL_CLK_OUT equals the phase.
  - On each 1→0 edge the lanes advance one bit.
  - After bit 0 of word w (w < NUM_WORDS−1), the next word loads from MEM_DATA and MEM_ADDR advances to w+2, but only while that index is < NUM_WORDS; otherwise MEM_ADDR holds.
  - Words are back-to-back with no gap bits.
  - After bit 0 of the last word: ENABLE_XFR_OUT, SERIAL_CLK_OUT and data all drop to 0, DONE pulses, state returns to IDLE.
- ABORT=1 in FETCH/SHIFT: on the next edge all serial outputs go to 0, state returns to IDLE, and DONE is not asserted. ABORT in IDLE has no effect.
- A TRIG_IN rise while BUSY is ignored and sets TRIG_OVERRUN. The trigger edge-detect register updates in every state, so a level held high across the end of a transfer does not retrigger.
- Reset mid-transfer behaves like ABORT, and additionally clears TRIG_OVERRUN, MEM_ADDR and the edge-detect register.

## Timing
- Reset values: every output 0, MEM_ADDR 0.
- Trigger latency: rising edge accepted at edge t0 → FETCH.
  - First data bit and ENABLE_XFR_OUT at t0+1.
  - First SERIAL_CLK_OUT rise at t0+2.
- Bit b of word w is driven during [t0+1+24w+2(11−b), +2 CLK).
- SERIAL_CLK_OUT rises mid-bit, so data is stable for one CLK either side of the rising edge. The receiver samples on the rise.
- ENABLE_XFR_OUT is high for exactly 24·NUM_WORDS CLK. DONE is high on edge t0+1+24·NUM_WORDS.
- The next trigger is acceptable one CLK after DONE.
- Memory: each MEM_ADDR is held ≥23 CLK before its data is consumed, so single-cycle BRAM latency suffices. No other outputs are combinational.

## Structure
- Package rd_link_pkg holds:
  - WORD_BITS;
  - the state enum (IDLE, FETCH, SHIFT);
  - BITS_PER_WORD_CLK = 2*WORD_BITS.
- Sub-module rd_word_serializer:
  - two-lane 12-bit parallel-load shift register plus the phase bit and bit counter;
  - inputs load/advance/clear;
  - outputs lane bits and last_bit.
- Top level holds the FSM, address counter, trigger edge detect and status.

## Test plan
- Basic: NUM_WORDS=4, BUF_NUM=2, MEM_DATA = {12'hA50+w, 12'h5A0+w}, trigger → MEM_ADDR sequence 0x1000..0x1003, then an rd_interface model captures 4 exact word pairs; ENABLE_XFR_OUT high 96 CLK; one DONE pulse at t0+97.
- Bit pattern: lane 0 word 0x800, lane 1 word 0x001 → lane 0 high only during the first bit period, lane 1 high only during the last; each bit spans exactly 2 CLK.
- Overrun: second TRIG_IN pulse mid-transfer → the transfer is unchanged and TRIG_OVERRUN=1. TRIG_IN held high through DONE → no second transfer.
- Abort: ABORT asserted during word 2, bit 5 → next edge all serial outputs 0, BUSY 0, no DONE; a new trigger then starts again from word 0.
- Reset mid-transfer: RST for 1 CLK during SHIFT → all outputs 0 and TRIG_OVERRUN cleared. Back-to-back: a trigger the cycle after DONE starts at +1 CLK with correct data.
